// File: rtl/point_tile_binner_if.sv
// Point binner bus: streaming point input plus binned-point and per-tile count dump outputs.
interface point_tile_binner_if #(
  parameter int unsigned GRID_LOG2 = 2,
  parameter int unsigned CNT_W     = 8
);
  localparam int unsigned IdW = 2 * GRID_LOG2;

  logic [127:0]     in_point;
  logic             in_valid;
  logic             in_done;
  logic [127:0]     tile_point;
  logic [IdW-1:0]   tile_id;
  logic             tile_valid;
  logic [CNT_W-1:0] count_out;
  logic [IdW-1:0]   count_tile_id;
  logic             count_valid;
  logic             count_last;
  logic [15:0]      drop_count;
  logic             busy;
  logic             overrun;

  modport master (
    output in_point, in_valid, in_done,
    input  tile_point, tile_id, tile_valid, count_out, count_tile_id, count_valid,
           count_last, drop_count, busy, overrun
  );

  modport slave (
    input  in_point, in_valid, in_done,
    output tile_point, tile_id, tile_valid, count_out, count_tile_id, count_valid,
           count_last, drop_count, busy, overrun
  );
endinterface

// File: rtl/point_tile_binner.sv
// Bins points into a square tile grid, counts per tile, and dumps counts at frame end.
// Define BINNER_SATURATE_EN for saturating tile counters; otherwise they wrap.
module point_tile_binner #(
  parameter int unsigned TILE_SHIFT = 8,
  parameter int unsigned GRID_LOG2  = 2,
  parameter int unsigned CNT_W      = 8
) (
  input logic                    clk,
  input logic                    reset,
  point_tile_binner_if.slave     bus
);
  localparam int unsigned IdW      = 2 * GRID_LOG2;
  localparam int unsigned NumTiles = 1 << IdW;
  localparam int unsigned RangeLsb = TILE_SHIFT + GRID_LOG2;

  typedef enum logic [1:0] {StAccum, StDrain, StDump} state_e;

  state_e state_q, state_d;

  logic             s1_valid_q, s1_in_range_q;
  logic [IdW-1:0]   s1_id_q;
  logic [127:0]     s1_point_q;
  logic             tile_valid_q;
  logic [IdW-1:0]   tile_id_q;
  logic [127:0]     tile_point_q;
  logic [IdW-1:0]   dump_idx_q, count_tile_id_q;
  logic [CNT_W-1:0] count_out_q;
  logic             count_valid_q, count_last_q;
  logic [15:0]      drop_count_q;
  logic             overrun_q;
  logic [CNT_W-1:0] cnt_q [NumTiles];

  logic             accept, busy, dumping, in_range, s1_bin, s1_drop;
  logic [IdW-1:0]   in_id;
  logic [CNT_W-1:0] cnt_cur, cnt_inc;

  // Non-negative and below grid size is the same as all bits above the tile index being zero.
  assign in_range = (bus.in_point[31:RangeLsb] == '0) && (bus.in_point[63:32+RangeLsb] == '0);
  assign in_id    = {bus.in_point[32+TILE_SHIFT +: GRID_LOG2],
                     bus.in_point[TILE_SHIFT +: GRID_LOG2]};
  assign busy     = (state_q != StAccum);
  assign accept   = bus.in_valid && !busy;
  assign dumping  = (state_q == StDump);
  assign s1_bin   = s1_valid_q && s1_in_range_q;
  assign s1_drop  = s1_valid_q && !s1_in_range_q;
  assign cnt_cur  = cnt_q[s1_id_q];

`ifdef BINNER_SATURATE_EN
  assign cnt_inc = (&cnt_cur) ? cnt_cur : cnt_cur + CNT_W'(1);
`else
  assign cnt_inc = cnt_cur + CNT_W'(1);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAccum: if (bus.in_done) state_d = StDrain;
      StDrain: state_d = StDump;
      StDump:  if (&dump_idx_q) state_d = StAccum;
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StAccum;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q      <= 1'b0;
      s1_in_range_q   <= 1'b0;
      s1_id_q         <= '0;
      s1_point_q      <= '0;
      tile_valid_q    <= 1'b0;
      tile_id_q       <= '0;
      tile_point_q    <= '0;
      dump_idx_q      <= '0;
      count_tile_id_q <= '0;
      count_out_q     <= '0;
      count_valid_q   <= 1'b0;
      count_last_q    <= 1'b0;
      drop_count_q    <= '0;
      overrun_q       <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_in_range_q <= in_range;
        s1_id_q       <= in_id;
        s1_point_q    <= bus.in_point;
      end
      tile_valid_q <= s1_bin;
      if (s1_bin) begin
        tile_id_q    <= s1_id_q;
        tile_point_q <= s1_point_q;
      end
      // Clearing after the last count cannot collide with a drop: no point is in flight then.
      if (count_last_q)                        drop_count_q <= '0;
      else if (s1_drop && !(&drop_count_q))    drop_count_q <= drop_count_q + 16'd1;
      count_valid_q <= dumping;
      count_last_q  <= dumping && (&dump_idx_q);
      if (dumping) begin
        count_out_q     <= cnt_q[dump_idx_q];
        count_tile_id_q <= dump_idx_q;
        dump_idx_q      <= dump_idx_q + IdW'(1);
      end
      if (busy && (bus.in_valid || bus.in_done)) overrun_q <= 1'b1;
    end
  end

  // The last point of a frame lands before DUMP starts, so clear and increment never overlap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumTiles; i++) cnt_q[i] <= '0;
    end else if (dumping) begin
      cnt_q[dump_idx_q] <= '0;
    end else if (s1_bin) begin
      cnt_q[s1_id_q] <= cnt_inc;
    end
  end

  assign bus.tile_point    = tile_point_q;
  assign bus.tile_id       = tile_id_q;
  assign bus.tile_valid    = tile_valid_q;
  assign bus.count_out     = count_out_q;
  assign bus.count_tile_id = count_tile_id_q;
  assign bus.count_valid   = count_valid_q;
  assign bus.count_last    = count_last_q;
  assign bus.drop_count    = drop_count_q;
  assign bus.busy          = busy;
  assign bus.overrun       = overrun_q;
endmodule

// File: tb/tb_point_tile_binner.sv
// Self-checking bench for point_tile_binner: directed scenarios plus randomized frames vs a model.
module tb_point_tile_binner;
  localparam int TS = 8;
  localparam int G  = 2;

  typedef struct {int cyc; logic [3:0] id; logic [127:0] pt;} tev_t;
  typedef struct {int cyc; logic [3:0] id; logic [7:0] cnt; logic last; logic [15:0] drop;} cev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  tev_t tq[$];
  cev_t cq[$];

  point_tile_binner_if #(.GRID_LOG2(2), .CNT_W(8)) bus ();

  point_tile_binner #(.TILE_SHIFT(8), .GRID_LOG2(2), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.tile_valid) tq.push_back('{cyc: cyc, id: bus.tile_id, pt: bus.tile_point});
      if (bus.count_valid)
        cq.push_back('{cyc: cyc, id: bus.count_tile_id, cnt: bus.count_out,
                       last: bus.count_last, drop: bus.drop_count});
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got time %0t, required < 500000", $time);
    $fatal(1);
  end

  function automatic logic [127:0] mkpt(input int x, input int y);
    logic [31:0] xv, yv;
    xv = x;
    yv = y;
    return {$urandom(), $urandom(), yv, xv};
  endfunction

  // Tile index by plain arithmetic on signed coordinates; -1 when out of range.
  function automatic int tile_of(input logic [127:0] p);
    int tx, ty;
    tx = $signed(p[31:0]) >>> TS;
    ty = $signed(p[63:32]) >>> TS;
    if (tx < 0 || ty < 0 || tx >= (1 << G) || ty >= (1 << G)) return -1;
    return ty * (1 << G) + tx;
  endfunction

  function automatic int cap(input int c);
`ifdef BINNER_SATURATE_EN
    return (c > 255) ? 255 : c;
`else
    return c % 256;
`endif
  endfunction

  task automatic drive(input logic v, input logic d, input logic [127:0] p);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_done  = d;
    bus.in_point = p;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_done  = 1'b0;
    bus.in_point = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tq.delete();
    cq.delete();
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_done  = 1'b0;
    bus.in_point = '0;
    #2;
    checks++;
    if ({bus.tile_valid, bus.count_valid, bus.count_last, bus.busy, bus.overrun,
         bus.drop_count, bus.count_out, bus.tile_id, bus.count_tile_id, bus.tile_point} !== '0)
      $display("FAIL reset_outputs: got nonzero outputs (busy=%b ovr=%b), required all 0",
               bus.busy, bus.overrun);
    else passed++;
  endtask

  task automatic test_single_point();
    logic [127:0] p;
    int n;
    do_reset();
    // Drive in the very first cycle after reset release.
    p = mkpt(32'h100, 32'h200);
    bus.in_valid = 1'b1;
    bus.in_point = p;
    n = cyc;
    idle(4);
    checks++;
    if (tq.size() !== 1) $display("FAIL single_count: got %0d tile strobes, required 1", tq.size());
    else passed++;
    if (tq.size() == 1) begin
      checks++;
      if (tq[0].cyc !== n + 2) $display("FAIL single_latency: got cycle %0d, required %0d",
                                        tq[0].cyc, n + 2);
      else passed++;
      checks++;
      if (tq[0].id !== 4'd9) $display("FAIL single_id: got %0d, required 9", tq[0].id);
      else passed++;
      checks++;
      if (tq[0].pt !== p) $display("FAIL single_point: got %h, required %h", tq[0].pt, p);
      else passed++;
    end
  endtask

  task automatic test_out_of_range();
    int nz;
    do_reset();
    drive(1'b1, 1'b0, mkpt(32'h400, 0));
    drive(1'b1, 1'b0, mkpt(32'hFFFF_FFFF, 0));
    drive(1'b0, 1'b1, '0);
    idle(24);
    checks++;
    if (tq.size() !== 0) $display("FAIL oor_strobes: got %0d, required 0", tq.size());
    else passed++;
    checks++;
    if (cq.size() !== 16) $display("FAIL oor_dump_len: got %0d, required 16", cq.size());
    else passed++;
    if (cq.size() == 16) begin
      nz = 0;
      foreach (cq[i]) if (cq[i].cnt != 0) nz++;
      checks++;
      if (nz !== 0) $display("FAIL oor_counts: got %0d nonzero tiles, required 0", nz);
      else passed++;
      checks++;
      if (cq[15].drop !== 16'd2 || cq[15].last !== 1'b1)
        $display("FAIL oor_drop: got drop=%0d last=%b, required drop=2 last=1",
                 cq[15].drop, cq[15].last);
      else passed++;
    end
    checks++;
    if (bus.drop_count !== 16'd0) $display("FAIL oor_drop_clear: got %0d, required 0",
                                           bus.drop_count);
    else passed++;
  endtask

  task automatic test_dump_timing();
    int n;
    do_reset();
    drive(1'b1, 1'b0, mkpt(32'h123, 32'h1A0));
    drive(1'b1, 1'b0, mkpt(32'h1FF, 32'h100));
    drive(1'b1, 1'b0, mkpt(32'h010, 32'h0FF));
    drive(1'b1, 1'b1, mkpt(32'h180, 32'h1FE));
    n = cyc;
    idle(24);
    checks++;
    if (cq.size() !== 16) $display("FAIL dump_len: got %0d, required 16", cq.size());
    else passed++;
    if (cq.size() == 16) begin
      checks++;
      if (cq[0].cyc !== n + 3 || cq[15].cyc !== n + 18)
        $display("FAIL dump_timing: got %0d..%0d, required %0d..%0d",
                 cq[0].cyc, cq[15].cyc, n + 3, n + 18);
      else passed++;
      checks++;
      if (cq[5].cnt !== 8'd3 || cq[0].cnt !== 8'd1 || cq[5].id !== 4'd5)
        $display("FAIL dump_counts: got t5=%0d t0=%0d, required t5=3 t0=1",
                 cq[5].cnt, cq[0].cnt);
      else passed++;
      checks++;
      if (cq[15].last !== 1'b1 || cq[14].last !== 1'b0 || cq[15].id !== 4'd15)
        $display("FAIL dump_last: got last15=%b last14=%b id=%0d, required 1 0 15",
                 cq[15].last, cq[14].last, cq[15].id);
      else passed++;
    end
  endtask

  task automatic test_counter_limit();
    do_reset();
    for (int i = 0; i < 300; i++) drive(1'b1, i == 299, mkpt($urandom_range(0, 255),
                                                            $urandom_range(0, 255)));
    idle(24);
    checks++;
    if (cq.size() != 16 || cq[0].cnt !== 8'(cap(300)))
      $display("FAIL counter_limit: got %0d (dump len %0d), required %0d",
               (cq.size() > 0) ? cq[0].cnt : 8'd0, cq.size(), cap(300));
    else passed++;
  endtask

  task automatic test_overrun();
    do_reset();
    drive(1'b1, 1'b1, mkpt(32'h010, 32'h010) | 128'h0 | {96'h0, 32'h200});
    drive(1'b0, 1'b1, '0);
    checks++;
    if (bus.busy !== 1'b1) $display("FAIL ovr_busy: got %b, required 1", bus.busy);
    else passed++;
    idle(7);
    drive(1'b1, 1'b0, mkpt(32'h200, 32'h010));
    idle(20);
    checks++;
    if (bus.overrun !== 1'b1) $display("FAIL ovr_flag: got %b, required 1", bus.overrun);
    else passed++;
    checks++;
    if (tq.size() !== 1 || cq.size() !== 16)
      $display("FAIL ovr_ignored: got %0d strobes %0d counts, required 1 and 16",
               tq.size(), cq.size());
    else passed++;
    if (cq.size() == 16) begin
      checks++;
      if (cq[2].cnt !== 8'd1) $display("FAIL ovr_frame1: got t2=%0d, required 1", cq[2].cnt);
      else passed++;
    end
    tq.delete();
    cq.delete();
    drive(1'b1, 1'b1, mkpt(32'h150, 32'h020));
    idle(24);
    checks++;
    if (cq.size() != 16 || cq[2].cnt !== 8'd0 || cq[1].cnt !== 8'd1)
      $display("FAIL ovr_frame2: got len=%0d t2=%0d t1=%0d, required 16 0 1", cq.size(),
               (cq.size() > 2) ? cq[2].cnt : 8'hx, (cq.size() > 1) ? cq[1].cnt : 8'hx);
    else passed++;
    checks++;
    if (bus.overrun !== 1'b1) $display("FAIL ovr_sticky: got %b, required 1", bus.overrun);
    else passed++;
  endtask

  task automatic test_reset_mid_dump();
    logic found;
    int nz;
    do_reset();
    drive(1'b1, 1'b0, mkpt(32'h310, 32'h0));
    drive(1'b1, 1'b0, mkpt(32'h320, 32'h0));
    drive(1'b1, 1'b1, mkpt(32'h210, 32'h100));
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.count_valid && bus.count_tile_id == 4'd7) found = 1'b1;
    end
    checks++;
    if (!found) $display("FAIL mid_dump_reach: got no tile 7, required tile 7 within 40 cycles");
    else passed++;
    #1;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_done  = 1'b0;
    #1;
    checks++;
    if ({bus.tile_valid, bus.count_valid, bus.count_last, bus.busy, bus.overrun,
         bus.drop_count, bus.count_out, bus.tile_id, bus.count_tile_id, bus.tile_point} !== '0)
      $display("FAIL mid_dump_reset: got busy=%b id=%0d, required all outputs 0",
               bus.busy, bus.count_tile_id);
    else passed++;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tq.delete();
    cq.delete();
    drive(1'b1, 1'b1, mkpt(32'h3AB, 32'h0C0));
    idle(24);
    checks++;
    if (cq.size() !== 16) $display("FAIL mid_dump_len: got %0d, required 16", cq.size());
    else passed++;
    if (cq.size() == 16) begin
      nz = 0;
      foreach (cq[i]) if (i != 3 && cq[i].cnt != 0) nz++;
      checks++;
      if (cq[3].cnt !== 8'd1 || nz !== 0)
        $display("FAIL mid_dump_counts: got t3=%0d others_nonzero=%0d, required 1 and 0",
                 cq[3].cnt, nz);
      else passed++;
    end
  endtask

  task automatic test_random_frames();
    logic [127:0] p;
    logic [127:0] exp_tiles[$];
    int exp_cnt[16];
    int exp_drop, n, t;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      tq.delete();
      cq.delete();
      exp_tiles.delete();
      foreach (exp_cnt[i]) exp_cnt[i] = 0;
      exp_drop = 0;
      n = $urandom_range(5, 40);
      for (int i = 0; i < n; i++) begin
        p = mkpt(int'($urandom_range(0, 1279)) - 128, int'($urandom_range(0, 1279)) - 128);
        if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, '0);
        drive(1'b1, i == n - 1, p);
        t = tile_of(p);
        if (t < 0) exp_drop++;
        else begin
          exp_cnt[t]++;
          exp_tiles.push_back(p);
        end
      end
      idle(24);
      checks++;
      if (tq.size() !== exp_tiles.size())
        $display("FAIL rnd_strobes f%0d: got %0d, required %0d", f, tq.size(), exp_tiles.size());
      else passed++;
      if (tq.size() == exp_tiles.size()) begin
        foreach (tq[i]) begin
          checks++;
          if (tq[i].pt !== exp_tiles[i] || 32'(tq[i].id) !== tile_of(exp_tiles[i]))
            $display("FAIL rnd_tile f%0d #%0d: got id %0d, required id %0d", f, i, tq[i].id,
                     tile_of(exp_tiles[i]));
          else passed++;
        end
      end
      checks++;
      if (cq.size() !== 16) $display("FAIL rnd_dump_len f%0d: got %0d, required 16", f, cq.size());
      else passed++;
      if (cq.size() == 16) begin
        foreach (cq[i]) begin
          checks++;
          if (cq[i].id !== 4'(i) || cq[i].cnt !== 8'(cap(exp_cnt[i])) ||
              cq[i].last !== (i == 15))
            $display("FAIL rnd_count f%0d t%0d: got id=%0d cnt=%0d last=%b, required cnt=%0d",
                     f, i, cq[i].id, cq[i].cnt, cq[i].last, cap(exp_cnt[i]));
          else passed++;
        end
        checks++;
        if (cq[15].drop !== 16'(exp_drop))
          $display("FAIL rnd_drop f%0d: got %0d, required %0d", f, cq[15].drop, exp_drop);
        else passed++;
      end
      checks++;
      if (bus.overrun !== 1'b0) $display("FAIL rnd_overrun f%0d: got 1, required 0", f);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_point();
    test_out_of_range();
    test_dump_timing();
    test_counter_limit();
    test_overrun();
    test_reset_mid_dump();
    test_random_frames();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
